// File: rtl/byte_spi_master.sv
// byte_spi_master
//   Initiator for the 8-bit-parallel SPI link. One 32-bit host request becomes
//   a 4-byte burst: writes serialise req_wdata onto sdo_o, reads gather sdi_i
//   into rsp_rdata. A byte is presented while scl_o is low and the responder
//   acts on the rising edge of scl_o.
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   req_valid/req_ready   host handshake (ready only while idle)
//   req_wr                0 = write, 1 = read
//   req_wdata[31:0]       write word
//   rsp_valid             one-cycle pulse at end of every burst
//   rsp_rdata[31:0]       read word (cleared by a write's completion)
//   busy                  high from accept until idle again
//   scl_o, sdo_o[7:0], sdi_i[7:0], wr_o, cs_o (active-high)   link pins
//
// Build option
//   SPI_MSB_FIRST_EN  defined: byte k is word[31-8k:24-8k] (MSB byte first)
//                     undefined: byte k is word[8k+7:8k]   (LSB byte first)
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// SETUP | cs_o up, byte 0 on the bus, scl_o low
// HIGH  | scl_o high, responder takes the byte
// LOW   | scl_o low, next byte presented
// DONE  | one cycle, rsp_valid pulse, cs_o dropped
// GAP   | cs_o held low before the next burst

module byte_spi_master #(
  parameter int CLK_DIV = 4,
  parameter int NBYTES  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        scl_o,
  output logic [7:0]  sdo_o,
  input  logic [7:0]  sdi_i,
  output logic        wr_o,
  output logic        cs_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_DONE,
    S_GAP
  } state_t;

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [1:0] LAST_IDX   = 2'(NBYTES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_div_cnt;
  logic [1:0]  r_idx;
  logic        r_last;
  logic [31:0] r_wdata;
  logic [31:0] r_rx;

  logic        w_phase_end;
  logic        w_enter_high;
  logic [4:0]  w_lane_cur;
  logic [4:0]  w_lane_next;
  logic [4:0]  w_lane_first;
  logic [7:0]  w_byte_first;
  logic [7:0]  w_byte_next;

  // Bit offset of byte k inside the 32-bit word.
  function automatic logic [4:0] lane_lsb(input logic [1:0] k);
`ifdef SPI_MSB_FIRST_EN
    lane_lsb = {~k, 3'b000};
`else
    lane_lsb = {k, 3'b000};
`endif
  endfunction

  assign w_phase_end  = (r_div_cnt == 8'd0);
  assign w_enter_high = (w_next == S_HIGH) && (r_state != S_HIGH);
  assign w_lane_cur   = lane_lsb(r_idx);
  assign w_lane_next  = lane_lsb(r_idx + 2'd1);
  assign w_lane_first = lane_lsb(2'd0);
  assign w_byte_first = req_wdata[w_lane_first +: 8];
  assign w_byte_next  = r_wdata[w_lane_next +: 8];

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid)   w_next = S_SETUP;
      S_SETUP: if (w_phase_end) w_next = S_HIGH;
      S_HIGH:  if (w_phase_end) w_next = S_LOW;
      S_LOW:   if (w_phase_end) w_next = r_last ? S_DONE : S_HIGH;
      S_DONE:                   w_next = S_GAP;
      S_GAP:   if (w_phase_end) w_next = S_IDLE;
      default:                  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= 8'd0;
      r_idx     <= 2'd0;
      r_last    <= 1'b0;
      r_wdata   <= 32'd0;
      r_rx      <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      scl_o     <= 1'b0;
      sdo_o     <= 8'd0;
      wr_o      <= 1'b0;
      cs_o      <= 1'b0;
    end else begin
      // every phase starts with a fresh CLK_DIV-cycle count
      if (w_next != r_state)     r_div_cnt <= DIV_RELOAD;
      else if (!w_phase_end)     r_div_cnt <= r_div_cnt - 8'd1;

      scl_o     <= (w_next == S_HIGH);
      cs_o      <= (w_next == S_SETUP) || (w_next == S_HIGH) || (w_next == S_LOW);
      rsp_valid <= (w_next == S_DONE);

      if (r_state == S_IDLE && req_valid) begin
        r_wdata <= req_wdata;
        wr_o    <= req_wr;
        sdo_o   <= req_wr ? 8'd0 : w_byte_first;
        r_idx   <= 2'd0;
        r_last  <= 1'b0;
        r_rx    <= 32'd0;
      end

      // leaving HIGH: advance to the next byte, or mark the trailing LOW
      if (r_state == S_HIGH && w_phase_end) begin
        if (r_idx == LAST_IDX) begin
          r_last <= 1'b1;
        end else begin
          r_idx <= r_idx + 2'd1;
          sdo_o <= wr_o ? 8'd0 : w_byte_next;
        end
      end

      // read data is taken in the cycle just before scl_o rises
      if (w_enter_high && wr_o) r_rx[w_lane_cur +: 8] <= sdi_i;

      // rsp_rdata only changes at completion so it stays stable between reads
      if (w_next == S_DONE) rsp_rdata <= wr_o ? r_rx : 32'd0;
    end
  end

endmodule

// File: tb/tb_byte_spi_master.sv
module tb_byte_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int top_chk  = 0;
  int top_fail = 0;

  // byte k of a word in link order
  function automatic logic [7:0] word_byte(input logic [31:0] w, input int k);
`ifdef SPI_MSB_FIRST_EN
    return w[8*(3-k) +: 8];
`else
    return w[8*k +: 8];
`endif
  endfunction

  function automatic int byte_pos(input int k);
`ifdef SPI_MSB_FIRST_EN
    return 3 - k;
`else
    return k;
`endif
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int D = (g == 0) ? 4 : 3;

    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic        scl_o;
    logic [7:0]  sdo_o;
    logic [7:0]  sdi_i;
    logic        wr_o;
    logic        cs_o;

    byte_spi_master #(.CLK_DIV(D), .NBYTES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr    (req_wr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .busy      (busy),
      .scl_o     (scl_o),
      .sdo_o     (sdo_o),
      .sdi_i     (sdi_i),
      .wr_o      (wr_o),
      .cs_o      (cs_o)
    );

    int drv_chk  = 0;
    int drv_fail = 0;
    int mon_chk  = 0;
    int mon_fail = 0;
    logic done = 1'b0;

    // Reference model: a burst is just a cycle count n since the accept edge.
    logic        m_busy  = 1'b0;
    int          m_n     = 0;
    logic        m_wr    = 1'b0;
    logic [31:0] m_wdata = 32'd0;
    logic [31:0] m_cap   = 32'd0;
    logic [31:0] m_rdata = 32'd0;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_busy  <= 1'b0;
        m_n     <= 0;
        m_rdata <= 32'd0;
      end else if (m_busy) begin
        m_n <= m_n + 1;
        if (m_wr && ((m_n + 1) % (2*D)) == D && (m_n + 1) < 8*D)
          m_cap[8*byte_pos((m_n + 1) / (2*D)) +: 8] <= sdi_i;
        if (m_n + 1 == 9*D) m_rdata <= m_wr ? m_cap : 32'd0;
        if (m_n + 1 == 10*D + 1) m_busy <= 1'b0;
      end else if (req_valid) begin
        m_busy  <= 1'b1;
        m_n     <= 0;
        m_wr    <= req_wr;
        m_wdata <= req_wdata;
        m_cap   <= 32'd0;
      end
    end

    task automatic mchk(input string name, input logic [31:0] act, input logic [31:0] exp);
      mon_chk++;
      if (act !== exp) begin
        mon_fail++;
        $display("FAIL %s (clkdiv %0d) t=%0t: got %h expected %h", name, D, $time, act, exp);
      end
    endtask

    task automatic dchk(input string name, input logic [31:0] act, input logic [31:0] exp);
      drv_chk++;
      if (act !== exp) begin
        drv_fail++;
        $display("FAIL %s (clkdiv %0d) t=%0t: got %h expected %h", name, D, $time, act, exp);
      end
    endtask

    // per-cycle compare against the model
    initial begin
      int p;
      int bi;
      forever begin
        @(negedge clk);
        mchk("req_ready", 32'(req_ready), 32'(!m_busy));
        mchk("busy", 32'(busy), 32'(m_busy));
        mchk("rsp_rdata", rsp_rdata, m_rdata);
        if (m_busy && m_n < 9*D) begin
          p  = m_n / D;
          bi = (p / 2 > 3) ? 3 : p / 2;
          mchk("cs_o", 32'(cs_o), 32'd1);
          mchk("scl_o", 32'(scl_o), 32'(p % 2));
          mchk("wr_o", 32'(wr_o), 32'(m_wr));
          mchk("sdo_o", 32'(sdo_o), m_wr ? 32'd0 : 32'(word_byte(m_wdata, bi)));
          mchk("rsp_valid", 32'(rsp_valid), 32'd0);
        end else begin
          mchk("cs_o", 32'(cs_o), 32'd0);
          mchk("scl_o", 32'(scl_o), 32'd0);
          mchk("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_n == 9*D));
        end
      end
    end

    // responder: random bytes, or 11,22,33,44 advanced on each scl rise
    logic       resp_mode = 1'b0;
    logic [7:0] rd_bytes [4];
    initial begin
      int   nrise;
      logic scl_prev;
      nrise    = 0;
      scl_prev = 1'b0;
      rd_bytes[0] = 8'h11;
      rd_bytes[1] = 8'h22;
      rd_bytes[2] = 8'h33;
      rd_bytes[3] = 8'h44;
      sdi_i = 8'h00;
      forever begin
        @(negedge clk);
        if (!cs_o) nrise = 0;
        else if (scl_o && !scl_prev) nrise++;
        scl_prev = scl_o;
        sdi_i = resp_mode ? rd_bytes[(nrise > 3) ? 3 : nrise] : 8'($urandom);
      end
    end

    logic [7:0] seen [4];

    task automatic do_xfer(input logic wr, input logic [31:0] data, output int lat, output int ncs);
      int   guard;
      int   nr;
      logic prev;
      @(negedge clk);
      req_valid = 1'b1;
      req_wr    = wr;
      req_wdata = data;
      guard = 0;
      while (!req_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) dchk("accept_timeout", 32'(guard), 32'd0);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat  = 0;
      ncs  = 0;
      nr   = 0;
      prev = 1'b0;
      while (!rsp_valid && lat < 300) begin
        if (cs_o) ncs++;
        if (scl_o && !prev && nr < 4) begin
          seen[nr] = sdo_o;
          nr++;
        end
        prev = scl_o;
        @(posedge clk);
        #1;
        lat++;
      end
      if (lat >= 300) dchk("rsp_timeout", 32'(lat), 32'd0);
    endtask

    initial begin
      int lat;
      int ncs;
      int pulses;
      int cyc;
      int first;
      int second;
      int nrsp;
      int exp_lat;
      logic [31:0] d;
      exp_lat   = (g == 0) ? 36 : 27;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_wr    = 1'b0;
      req_wdata = 32'd0;
      repeat (3) @(negedge clk);
      dchk("rst_ready", 32'(req_ready), 32'd1);
      dchk("rst_busy", 32'(busy), 32'd0);
      dchk("rst_cs", 32'(cs_o), 32'd0);
      dchk("rst_scl", 32'(scl_o), 32'd0);
      dchk("rst_rdata", rsp_rdata, 32'd0);
      rst_n = 1'b1;

      // directed write with byte-order pin
      do_xfer(1'b0, 32'hA1B2C3D4, lat, ncs);
      dchk("wr_latency", 32'(lat), 32'(exp_lat));
      dchk("wr_cs_cycles", 32'(ncs), 32'(exp_lat));
      dchk("wr_rdata", rsp_rdata, 32'd0);
`ifdef SPI_MSB_FIRST_EN
      dchk("wr_bytes", {seen[0], seen[1], seen[2], seen[3]}, 32'hA1B2C3D4);
`else
      dchk("wr_bytes", {seen[0], seen[1], seen[2], seen[3]}, 32'hD4C3B2A1);
`endif

      // directed read from the in-order responder
      resp_mode = 1'b1;
      do_xfer(1'b1, 32'hFFFFFFFF, lat, ncs);
      dchk("rd_latency", 32'(lat), 32'(exp_lat));
`ifdef SPI_MSB_FIRST_EN
      dchk("rd_data", rsp_rdata, 32'h11223344);
`else
      dchk("rd_data", rsp_rdata, 32'h44332211);
`endif
      resp_mode = 1'b0;

      // req_valid held across three bursts
      @(negedge clk);
      req_valid = 1'b1;
      req_wr    = 1'b0;
      req_wdata = $urandom;
      pulses = 0;
      cyc    = 0;
      first  = 0;
      second = 0;
      while (pulses < 3 && cyc < 2000) begin
        @(posedge clk);
        #1;
        cyc++;
        if (rsp_valid) begin
          if (pulses == 0) first = cyc;
          if (pulses == 1) second = cyc;
          pulses++;
        end
      end
      req_valid = 1'b0;
      dchk("held_pulses", 32'(pulses), 32'd3);
      dchk("held_spacing", 32'(second - first), (g == 0) ? 32'd42 : 32'd32);

      // reset during the second HIGH phase
      @(negedge clk);
      req_valid = 1'b1;
      req_wr    = 1'b0;
      req_wdata = $urandom | 32'h01010101;
      cyc = 0;
      while (!req_ready && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (3*D) @(posedge clk);
      #1;
      dchk("hi2_scl", 32'(scl_o), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      dchk("arst_scl", 32'(scl_o), 32'd0);
      dchk("arst_cs", 32'(cs_o), 32'd0);
      dchk("arst_sdo", 32'(sdo_o), 32'd0);
      dchk("arst_wr", 32'(wr_o), 32'd0);
      dchk("arst_busy", 32'(busy), 32'd0);
      dchk("arst_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      nrsp = 0;
      repeat (12*D) begin
        @(negedge clk);
        if (rsp_valid) nrsp++;
      end
      dchk("no_rsp_after_rst", 32'(nrsp), 32'd0);
      do_xfer(1'b0, 32'h0F1E2D3C, lat, ncs);
      dchk("post_rst_latency", 32'(lat), 32'(exp_lat));

      // randomized back-to-back traffic, random sdi
      repeat (30) begin
        d = $urandom;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_xfer(1'($urandom_range(0, 1)), d, lat, ncs);
        dchk("rand_latency", 32'(lat), 32'(exp_lat));
      end
      repeat (12*D) @(negedge clk);
      done = 1'b1;
    end
  end

  initial begin
    int guard;
    guard = 0;
    while (!(g_inst[0].done && g_inst[1].done) && guard < 50000) begin
      @(posedge clk);
      guard++;
    end
    top_chk++;
    if (guard >= 50000) begin
      top_fail++;
      $display("FAIL run_timeout: got %0d cycles required under 50000", guard);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             top_chk + g_inst[0].drv_chk + g_inst[0].mon_chk + g_inst[1].drv_chk + g_inst[1].mon_chk,
             top_fail + g_inst[0].drv_fail + g_inst[0].mon_fail + g_inst[1].drv_fail + g_inst[1].mon_fail);
    $finish;
  end

endmodule
